// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity sense and data width.
// Used by both the transmit and receive controllers.
package uart_pkg;

  localparam int   DATA_W      = 8;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Clear holds it at zero (used while the line is idle).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = !clear && (cnt == CNT_MAX);

  // Wrap at the end of every bit period; held at zero while cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller. Drives the neighbouring piso (load_data,
// shift), takes its serial data_bit and builds start / 8 data / [parity] /
// stop on tx.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (tx=0)
// DATA   | data bits LSB-first from piso, bit_idx 0..7
// PARITY | optional parity bit
// STOP   | 1 or 2 stop bits (tx=1), stop_idx counts them
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_start,
  output logic tx_ready,
  output logic tx_busy,
  output logic tx_done,
  output logic load_data,
  output logic shift,
  input  logic data_bit,
  output logic tx
);

  import uart_pkg::*;

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_INV   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_t state;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        parity_acc;
  logic        bit_end;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  assign tx_ready = (state == IDLE);
  assign tx_busy  = !tx_ready;

  // Frame sequencing, bit/stop indices, running parity and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_acc <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state      <= START;
            parity_acc <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            parity_acc <= parity_acc ^ data_bit;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PAR_EN) begin
                state <= PARITY;
              end else begin
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // piso strobes and the line mux; tx depends only on flops, never on tx_start.
  always_comb begin
    load_data = (state == IDLE) && tx_start;
    shift     = bit_end && ((state == START) || ((state == DATA) && (bit_idx != 3'd7)));
    tx        = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = data_bit;
      PARITY:  tx = parity_acc ^ PAR_INV;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: five parameterisations side by side, each
// with its own small piso model feeding data_bit.
//  inst 0: CPB 4, no parity, 1 stop   inst 1: CPB 4, even parity
//  inst 2: CPB 4, odd parity          inst 3: CPB 4, 2 stop bits
//  inst 4: CPB 2, no parity, 1 stop
module tb_uart_tx_ctrl;

  logic       clk;
  logic       reset;
  logic       tx_start  [5];
  logic       tx_ready  [5];
  logic       tx_busy   [5];
  logic       tx_done   [5];
  logic       load_data [5];
  logic       shift     [5];
  logic       data_bit  [5];
  logic       tx        [5];
  logic [7:0] tx_data   [5];
  logic [7:0] sreg      [5];

  int checks = 0;
  int errors = 0;
  int n_load  [5];
  int n_shift [5];
  int n_done  [5];
  int n_overlap = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start[0]), .tx_ready(tx_ready[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .load_data(load_data[0]),
    .shift(shift[0]), .data_bit(data_bit[0]), .tx(tx[0]));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start[1]), .tx_ready(tx_ready[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .load_data(load_data[1]),
    .shift(shift[1]), .data_bit(data_bit[1]), .tx(tx[1]));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start[2]), .tx_ready(tx_ready[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .load_data(load_data[2]),
    .shift(shift[2]), .data_bit(data_bit[2]), .tx(tx[2]));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(reset), .tx_start(tx_start[3]), .tx_ready(tx_ready[3]),
    .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .load_data(load_data[3]),
    .shift(shift[3]), .data_bit(data_bit[3]), .tx(tx[3]));
  uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut4 (
    .clk(clk), .reset(reset), .tx_start(tx_start[4]), .tx_ready(tx_ready[4]),
    .tx_busy(tx_busy[4]), .tx_done(tx_done[4]), .load_data(load_data[4]),
    .shift(shift[4]), .data_bit(data_bit[4]), .tx(tx[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // piso model: load captures the byte, each shift presents the next LSB.
  always_ff @(posedge clk or negedge reset) begin
    for (int i = 0; i < 5; i++) begin
      if (!reset) begin
        sreg[i]     <= '0;
        data_bit[i] <= 1'b1;
      end else if (load_data[i]) begin
        sreg[i] <= tx_data[i];
      end else if (shift[i]) begin
        data_bit[i] <= sreg[i][0];
        sreg[i]     <= {1'b0, sreg[i][7:1]};
      end
    end
  end

  // Strobe counters and exclusivity tracking, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (load_data[i] === 1'b1) n_load[i]++;
      if (shift[i] === 1'b1) n_shift[i]++;
      if (tx_done[i] === 1'b1) n_done[i]++;
      if (load_data[i] === 1'b1 && shift[i] === 1'b1) n_overlap++;
      if (tx_ready[i] === 1'b1 && tx_busy[i] === 1'b1) n_overlap++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Sends one byte on instance idx and records tx for every busy cycle.
  // Entered and left just after a rising edge with the instance idle.
  task automatic capture(input int idx, input logic [7:0] b, output int nbusy,
                         output logic [63:0] line, output logic done_seen);
    line      = '0;
    nbusy     = 0;
    done_seen = 1'b0;
    tx_data[idx]  = b;
    tx_start[idx] = 1'b1;
    @(posedge clk); #1;
    tx_start[idx] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_busy[idx]) begin
        if (nbusy < 64) line[nbusy] = tx[idx];
        nbusy++;
      end else begin
        done_seen = tx_done[idx];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_start[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end
    #12;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || tx_ready[i] !== 1'b1 || tx_busy[i] !== 1'b0 ||
          tx_done[i] !== 1'b0 || load_data[i] !== 1'b0 || shift[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got tx=%b rdy=%b busy=%b done=%b ld=%b sh=%b exp 1 1 0 0 0 0",
                 i, tx[i], tx_ready[i], tx_busy[i], tx_done[i], load_data[i], shift[i]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame;
    int nb, l0, s0, d0;
    logic [63:0] ln;
    logic dn;
    logic [9:0] f;
    f  = 10'b1_10100101_0;
    l0 = n_load[0]; s0 = n_shift[0]; d0 = n_done[0];
    capture(0, 8'hA5, nb, ln, dn);
    checks++;
    if (nb !== 40) begin errors++; $display("FAIL t1_busy_cycles got=%0d exp=40", nb); end
    checks++;
    if (dn !== 1'b1) begin errors++; $display("FAIL t1_done_at_end got=%b exp=1", dn); end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (ln[c] !== f[c/4]) begin
        errors++; $display("FAIL t1_tx cycle=%0d got=%b exp=%b", c, ln[c], f[c/4]);
      end
    end
    checks++;
    if (n_done[0] - d0 !== 1) begin errors++; $display("FAIL t1_done_pulses got=%0d exp=1", n_done[0] - d0); end
    checks++;
    if (n_load[0] - l0 !== 1) begin errors++; $display("FAIL t1_load_pulses got=%0d exp=1", n_load[0] - l0); end
    checks++;
    if (n_shift[0] - s0 !== 8) begin errors++; $display("FAIL t1_shift_pulses got=%0d exp=8", n_shift[0] - s0); end
    checks++;
    if (tx_done[0] !== 1'b0 || tx_ready[0] !== 1'b1) begin
      errors++; $display("FAIL t1_after_done got done=%b rdy=%b exp 0 1", tx_done[0], tx_ready[0]);
    end
  endtask

  task automatic test_parity;
    int nb;
    logic [63:0] ln;
    logic dn;
    int inst [3];
    logic [7:0] byt [3];
    logic [10:0] fr [3];
    inst[0] = 1; byt[0] = 8'hA5; fr[0] = 11'b1_0_10100101_0;
    inst[1] = 2; byt[1] = 8'hA5; fr[1] = 11'b1_1_10100101_0;
    inst[2] = 1; byt[2] = 8'h07; fr[2] = 11'b1_1_00000111_0;
    for (int k = 0; k < 3; k++) begin
      capture(inst[k], byt[k], nb, ln, dn);
      checks++;
      if (nb !== 44 || dn !== 1'b1) begin
        errors++; $display("FAIL t2_frame_len case=%0d got=%0d done=%b exp=44 done=1", k, nb, dn);
      end
      for (int c = 0; c < 44; c++) begin
        checks++;
        if (ln[c] !== fr[k][c/4]) begin
          errors++; $display("FAIL t2_tx case=%0d cycle=%0d got=%b exp=%b", k, c, ln[c], fr[k][c/4]);
        end
      end
    end
  endtask

  task automatic test_two_stop;
    int nb;
    logic [63:0] ln;
    logic dn;
    logic e;
    capture(3, 8'h00, nb, ln, dn);
    checks++;
    if (nb !== 44 || dn !== 1'b1) begin
      errors++; $display("FAIL t3_frame_len got=%0d done=%b exp=44 done=1", nb, dn);
    end
    for (int c = 0; c < 44; c++) begin
      e = (c >= 36);
      checks++;
      if (ln[c] !== e) begin
        errors++; $display("FAIL t3_tx cycle=%0d got=%b exp=%b", c, ln[c], e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int l0, s0, d0, nxt;
    logic [9:0] f1, f2;
    f1 = 10'b1_01010101_0;
    f2 = 10'b1_00111100_0;
    l0 = n_load[0]; s0 = n_shift[0]; d0 = n_done[0];
    tx_data[0]  = 8'h55;
    tx_start[0] = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 40) begin
        checks++;
        if (tx[0] !== f1[(c-1)/4] || tx_busy[0] !== 1'b1) begin
          errors++; $display("FAIL t4_frame1 cycle=%0d got tx=%b busy=%b exp tx=%b busy=1", c, tx[0], tx_busy[0], f1[(c-1)/4]);
        end
      end else if (c == 41 || c == 82) begin
        checks++;
        if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || tx_done[0] !== 1'b1) begin
          errors++; $display("FAIL t4_done_cycle cycle=%0d got tx=%b rdy=%b done=%b exp 1 1 1", c, tx[0], tx_ready[0], tx_done[0]);
        end
      end else if (c >= 42 && c <= 81) begin
        checks++;
        if (tx[0] !== f2[(c-42)/4] || tx_busy[0] !== 1'b1) begin
          errors++; $display("FAIL t4_frame2 cycle=%0d got tx=%b busy=%b exp tx=%b busy=1", c, tx[0], tx_busy[0], f2[(c-42)/4]);
        end
      end else if (c > 82) begin
        checks++;
        if (tx_busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
          errors++; $display("FAIL t4_no_third cycle=%0d got busy=%b tx=%b exp 0 1", c, tx_busy[0], tx[0]);
        end
      end
      @(posedge clk); #1;
      nxt = c + 1;
      tx_data[0]  = 8'h3C;
      tx_start[0] = (nxt <= 41) || (nxt >= 42 && nxt < 70 && (nxt % 7) == 0);
    end
    tx_start[0] = 1'b0;
    checks++;
    if (n_done[0] - d0 !== 2) begin errors++; $display("FAIL t4_done_pulses got=%0d exp=2", n_done[0] - d0); end
    checks++;
    if (n_load[0] - l0 !== 2) begin errors++; $display("FAIL t4_load_pulses got=%0d exp=2", n_load[0] - l0); end
    checks++;
    if (n_shift[0] - s0 !== 16) begin errors++; $display("FAIL t4_shift_pulses got=%0d exp=16", n_shift[0] - s0); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, nb;
    logic [63:0] ln;
    logic dn;
    logic [9:0] f;
    tx_data[0]  = 8'hFF;
    tx_start[0] = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c == 18) begin
        checks++;
        if (tx_busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
          errors++; $display("FAIL t5_in_bit3 got busy=%b tx=%b exp 1 1", tx_busy[0], tx[0]);
        end
      end
      @(posedge clk); #1;
      tx_start[0] = 1'b0;
    end
    d0 = n_done[0];
    reset = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_ready[0] !== 1'b1 || tx_done[0] !== 1'b0) begin
      errors++; $display("FAIL t5_async_abort got tx=%b busy=%b rdy=%b done=%b exp 1 0 1 0", tx[0], tx_busy[0], tx_ready[0], tx_done[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_done[0] - d0 !== 0) begin errors++; $display("FAIL t5_no_done got=%0d exp=0", n_done[0] - d0); end
    f = 10'b1_10000001_0;
    capture(0, 8'h81, nb, ln, dn);
    checks++;
    if (nb !== 40 || dn !== 1'b1) begin
      errors++; $display("FAIL t5_after_len got=%0d done=%b exp=40 done=1", nb, dn);
    end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (ln[c] !== f[c/4]) begin
        errors++; $display("FAIL t5_tx cycle=%0d got=%b exp=%b", c, ln[c], f[c/4]);
      end
    end
  endtask

  task automatic test_min_baud;
    int nb, s0;
    logic [63:0] ln;
    logic dn;
    logic [9:0] f;
    f  = 10'b1_10000000_0;
    s0 = n_shift[4];
    capture(4, 8'h80, nb, ln, dn);
    checks++;
    if (nb !== 20 || dn !== 1'b1) begin
      errors++; $display("FAIL t6_frame_len got=%0d done=%b exp=20 done=1", nb, dn);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (ln[c] !== f[c/2]) begin
        errors++; $display("FAIL t6_tx cycle=%0d got=%b exp=%b", c, ln[c], f[c/2]);
      end
    end
    checks++;
    if (ln[16] !== 1'b1 || ln[17] !== 1'b1) begin
      errors++; $display("FAIL t6_bit7 got=%b%b exp=11", ln[16], ln[17]);
    end
    checks++;
    if (n_shift[4] - s0 !== 8) begin errors++; $display("FAIL t6_shift_pulses got=%0d exp=8", n_shift[4] - s0); end
  endtask

  task automatic test_exclusive;
    checks++;
    if (n_overlap !== 0) begin
      errors++; $display("FAIL excl_strobes got=%0d exp=0", n_overlap);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      n_load[i]  = 0;
      n_shift[i] = 0;
      n_done[i]  = 0;
    end
    test_reset();
    test_basic_frame();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_baud();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
